mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
- Downstream neighbour of the data-memory (MEM) stage in the 5-stage 64-bit pipeline.
- Holds the MEM/WB pipeline register and selects the writeback value (load data or ALU result).
- Owns the 32x64 integer register file: writes it, and serves the decode stage's two read ports with write-through bypass.
- Counts retired instructions for debug/perf.

Parameters:
- XLEN, 64, datapath width.
- NREG, 32, number of architectural registers (x0 hardwired to zero).
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_valid  in  1  MEM stage holds a live instruction this cycle.
- m_regwrite  in  1  instruction writes rd.
- m_memtoreg  in  1  1 = writeback load data, 0 = ALU result.
- m_rd  in  5  destination register index.
- m_alu_result  in  XLEN  ALU result presented to MEM this cycle.
- m_read_data  in  XLEN  registered load data from data memory; valid the cycle after the MEM-stage edge.
- stall  in  1  hold WB register; suppress writeback.
- flush  in  1  kill the instruction entering WB.
- rs1_addr  in  5  decode read port 1 index.
- rs2_addr  in  5  decode read port 2 index.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational.
- wb_en  out  1  register-file write occurring this cycle (for forwarding unit).
- wb_rd  out  5  register being written.
- wb_data  out  XLEN  value being written.
- retire_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0): wb_valid_q=0; rd_q, regwrite_q, memtoreg_q and alu_q cleared; hold_valid=0; retire_count=0; all registers=0; wb_en=0, wb_rd=0, wb_data=0.
- Capture: on posedge with stall=0, latch m_valid&~flush, m_regwrite, m_memtoreg, m_rd and m_alu_result into the WB register. Control lands on the same edge the memory registers its read data, so m_read_data is aligned with the WB register contents.
- Write value: wb_data = memtoreg_q ? load_data : alu_q.
  - load_data = hold_q if hold_valid=1, else m_read_data.
- Write enable: wb_en = wb_valid_q & regwrite_q & (rd_q != 0) & ~stall.
- Register write: regfile[rd_q] <= wb_data on the posedge where wb_en=1.
- Latency: MEM-input edge to register-file update is one cycle; the value is readable through the bypass during the cycle wb_en is high.
- Stall:
  - WB register holds and no write occurs.
  - The data memory does not hold its output, so on the first stalled cycle hold_q <= m_read_data and hold_valid <= 1.
  - hold_valid clears on the first non-stalled edge.
  - Multi-cycle stalls keep the first captured value.
- Flush:
  - Flush=1 at an edge loads wb_valid_q=0 (bubble); other fields may load but are don't-care.
  - Flush takes priority over stall: the register updates to a bubble even when stall=1, and hold_valid clears.
- Read ports:
  - Address 0 returns 0.
  - If wb_en=1 and wb_rd equals the address, return wb_data (write-through bypass).
  - Otherwise return the array contents.
  - Both ports are evaluated independently.
- Writes to x0 are dropped; the register stays 0.
- retire_count increments by 1 on each edge where wb_valid_q=1 and stall=0, whether or not the instruction writes a register. It wraps at 2^CNT_W-1 -> 0.
- Reset mid-stall: all of the above clear immediately; no write occurs on the next edge unless new valid input arrives.

Decomposition:
- Shared pipeline package holds:
  - XLEN and NREG constants.
  - REG_IDX_W = 5.
  - A packed MEM/WB bundle typedef {valid, regwrite, memtoreg, rd, alu}, reused by the MEM-stage output.
- One sub-module, regfile_2r1w:
  - NREG x XLEN array, async reset to 0.
  - One synchronous write port, two combinational read ports.
  - Bypass and x0 handling live inside it.
- The WB register, hold logic and counter stay in the top module.

Test Plan:
- ALU writeback: m_valid=1, regwrite=1, memtoreg=0, rd=5, alu=0x1234. On the next cycle wb_en=1, wb_rd=5, wb_data=0x1234, rs1_addr=5 reads 0x1234 (bypass); a later cycle reads 0x1234 from the array; retire_count=1.
- Load writeback: memtoreg=1, rd=7, m_read_data=0xDEADBEEF_00000001 in the WB cycle -> x7 = that value; alu value ignored.
- x0 protection: regwrite=1, rd=0, alu=0xFF -> wb_en=0, rs1_addr=0 reads 0, retire_count still increments.
- Stall with load:
  - Load to rd=3; stall=1 for 3 cycles while m_read_data changes 0xAA -> 0xBB -> 0xCC.
  - No write during the stall.
  - After release, x3 = 0xAA, and retire_count increments exactly once.
- Flush priority: valid load to rd=9 with flush=1 and stall=1 at the same edge -> wb_valid_q=0, x9 unchanged, no retire.
- Async reset: assert rst_n=0 mid-stall, between edges -> outputs and retire_count go to 0 immediately; all registers read 0 after release.

Source files
------------

// File: rtl/mem_wb_writeback_pkg.sv
// rtl/mem_wb_writeback_pkg.sv - shared pipeline constants and MEM/WB bundle type
//
// Holds the datapath width, register count and register-index width used by
// the writeback stage and register file. The packed MEM/WB bundle is also the
// shape of the MEM-stage output.
package mem_wb_writeback_pkg;

    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 32;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memtoreg;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      alu;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_writeback_regfile_2r1w.sv
// rtl/mem_wb_writeback_regfile_2r1w.sv - integer register file, 2 read / 1 write, write-through bypass
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (array clears to 0)
//   i_we, i_waddr, i_wdata synchronous write port; writes to x0 are dropped
//   i_raddr1, i_raddr2    combinational read addresses
//   o_rdata1, o_rdata2    read data: 0 for x0, write data when the port address
//                         matches a write in progress, otherwise array contents
module regfile_2r1w
    import mem_wb_writeback_pkg::*;
#(
    parameter int DW = mem_wb_writeback_pkg::XLEN,
    parameter int NR = mem_wb_writeback_pkg::NREG,
    parameter int AW = mem_wb_writeback_pkg::REG_IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2
);

    logic [DW-1:0] r_regs [NR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Bypass lets decode see a value in the same cycle it is being written,
    // so no extra forwarding path is needed from WB back to decode.
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (i_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (i_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB pipeline register, writeback select, register file and retire counter
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m_valid/m_regwrite/m_memtoreg/m_rd/m_alu_result
//                              MEM-stage instruction captured into WB
//   m_read_data                load data, aligned with the WB register contents
//   stall                      hold WB register, suppress writeback
//   flush                      turn the instruction entering WB into a bubble
//   rs1_addr/rs2_addr -> rs1_data/rs2_data   decode read ports
//   wb_en/wb_rd/wb_data        register-file write occurring this cycle
//   retire_count               retired-instruction count (wraps)
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int XLEN  = mem_wb_writeback_pkg::XLEN,
    parameter int NREG  = mem_wb_writeback_pkg::NREG,
    parameter int CNT_W = mem_wb_writeback_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_valid,
    input  logic                 m_regwrite,
    input  logic                 m_memtoreg,
    input  logic [REG_IDX_W-1:0] m_rd,
    input  logic [XLEN-1:0]      m_alu_result,
    input  logic [XLEN-1:0]      m_read_data,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 wb_en,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic [CNT_W-1:0]     retire_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mem_wb_t          w_mem;
    mem_wb_t          r_wb;
    logic [XLEN-1:0]  r_hold;
    logic             r_hold_valid;
    logic [CNT_W-1:0] r_retire;
    logic [XLEN-1:0]  w_load_data;
    logic [XLEN-1:0]  w_wb_data;
    logic             w_wb_en;
    logic             w_advance;

    assign w_mem = '{valid:    m_valid & ~flush,
                     regwrite: m_regwrite,
                     memtoreg: m_memtoreg,
                     rd:       m_rd,
                     alu:      m_alu_result};

    // Flush overrides stall so a killed instruction never lingers in WB.
    assign w_advance = flush | ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb         <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_retire     <= '0;
        end else begin
            if (w_advance) begin
                r_wb         <= w_mem;
                r_hold_valid <= 1'b0;
            end else if (!r_hold_valid) begin
                // Memory output moves on during a stall; keep only the first
                // value, which belongs to the instruction held in WB.
                r_hold       <= m_read_data;
                r_hold_valid <= 1'b1;
            end
            if (r_wb.valid && !stall) begin
                r_retire <= r_retire + CNT_ONE;
            end
        end
    end

    assign w_load_data = r_hold_valid ? r_hold : m_read_data;
    assign w_wb_data   = r_wb.memtoreg ? w_load_data : r_wb.alu;
    assign w_wb_en     = r_wb.valid & r_wb.regwrite & (r_wb.rd != '0) & ~stall;

    regfile_2r1w #(
        .DW (XLEN),
        .NR (NREG),
        .AW (REG_IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_wb_en),
        .i_waddr  (r_wb.rd),
        .i_wdata  (w_wb_data),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (rs1_data),
        .o_rdata2 (rs2_data)
    );

    assign wb_en        = w_wb_en;
    assign wb_rd        = r_wb.rd;
    assign wb_data      = w_wb_data;
    assign retire_count = r_retire;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - scoreboard testbench for mem_wb_writeback
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_valid = 1'b0, m_regwrite = 1'b0, m_memtoreg = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [63:0] m_alu_result = '0, m_read_data = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [63:0] rs1_data, rs2_data, wb_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    mem_wb_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
        .m_rd(m_rd), .m_alu_result(m_alu_result), .m_read_data(m_read_data),
        .stall(stall), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .retire_count(retire_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [4:0] rd; logic [63:0] data; } wr_t;
    typedef struct { logic we; logic [63:0] rs1; logic [63:0] rs2; logic [31:0] cnt; } obs_t;
    wr_t  q_wr[$];
    obs_t q_obs[$];

    // Reference model: the instruction sitting in WB, its saved load value,
    // the architectural register array and the retire tally.
    logic [63:0] ref_regs [32];
    logic        ref_valid, ref_regwrite, ref_memtoreg;
    logic [4:0]  ref_rd;
    logic [63:0] ref_alu, ref_hold;
    logic        ref_hold_valid;
    logic [31:0] ref_count;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mdl_value();
        logic [63:0] load;
        load = ref_hold_valid ? ref_hold : m_read_data;
        return ref_memtoreg ? load : ref_alu;
    endfunction

    function automatic logic mdl_we();
        return ref_valid && ref_regwrite && (ref_rd != 5'd0) && !stall;
    endfunction

    function automatic logic [63:0] mdl_read(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (mdl_we() && a == ref_rd) return mdl_value();
        return ref_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        ref_valid = 0; ref_regwrite = 0; ref_memtoreg = 0; ref_rd = '0;
        ref_alu = '0; ref_hold = '0; ref_hold_valid = 0; ref_count = '0;
    endtask

    // What one rising edge does to the architectural state, given the inputs
    // that were present during the cycle that just ended.
    task automatic model_edge();
        if (mdl_we()) ref_regs[ref_rd] = mdl_value();
        if (ref_valid && !stall) ref_count = ref_count + 1;
        if (flush) begin
            ref_valid = 0;
            ref_hold_valid = 0;
        end else if (stall) begin
            if (!ref_hold_valid) begin
                ref_hold = m_read_data;
                ref_hold_valid = 1;
            end
        end else begin
            ref_valid = m_valid; ref_regwrite = m_regwrite; ref_memtoreg = m_memtoreg;
            ref_rd = m_rd; ref_alu = m_alu_result; ref_hold_valid = 0;
        end
    endtask

    task automatic push_expect();
        obs_t o;
        wr_t  w;
        o.we  = mdl_we();
        o.rs1 = mdl_read(rs1_addr);
        o.rs2 = mdl_read(rs2_addr);
        o.cnt = ref_count;
        q_obs.push_back(o);
        if (o.we) begin
            w.rd = ref_rd;
            w.data = mdl_value();
            q_wr.push_back(w);
        end
    endtask

    task automatic cycle(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] rdata,
                         input logic st, input logic fl, input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        model_edge();
        #1;
        m_valid = v; m_regwrite = rw; m_memtoreg = mr; m_rd = rd;
        m_alu_result = alu; m_read_data = rdata; stall = st; flush = fl;
        rs1_addr = a1; rs2_addr = a2;
        push_expect();
    endtask

    task automatic idle(input logic [4:0] a1, input logic [63:0] rdata, input logic st);
        cycle(0, 0, 0, 5'd0, 64'd0, rdata, st, 0, a1, 5'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q_obs.delete();
        q_wr.delete();
        model_reset();
        m_valid = 0; m_regwrite = 0; m_memtoreg = 0; m_rd = '0; m_alu_result = '0;
        m_read_data = '0; stall = 0; flush = 0; rs1_addr = '0; rs2_addr = '0;
        #1;
        check64("reset_wb_en", {63'd0, wb_en}, 64'd0);
        check64("reset_wb_rd", {59'd0, wb_rd}, 64'd0);
        check64("reset_wb_data", wb_data, 64'd0);
        check64("reset_retire_count", {32'd0, retire_count}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_expect();
    endtask

    // Monitor: pops the expected per-cycle view and any expected write.
    always @(negedge clk) begin
        obs_t o;
        wr_t  w;
        if (rst_n) begin
            if (q_obs.size() > 0) begin
                o = q_obs.pop_front();
                check64("wb_en", {63'd0, wb_en}, {63'd0, o.we});
                check64("rs1_data", rs1_data, o.rs1);
                check64("rs2_data", rs2_data, o.rs2);
                check64("retire_count", {32'd0, retire_count}, {32'd0, o.cnt});
            end
            if (wb_en) begin
                if (q_wr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: wb_en=1 wb_rd=%0d, expected no write", wb_rd);
                end else begin
                    w = q_wr.pop_front();
                    check64("wb_rd", {59'd0, wb_rd}, {59'd0, w.rd});
                    check64("wb_data", wb_data, w.data);
                end
            end
        end
    end

    initial begin
        logic [4:0] rd, a1, a2;
        model_reset();
        do_reset();

        // ALU writeback to x5
        cycle(1, 1, 0, 5'd5, 64'h1234, 64'd0, 0, 0, 5'd0, 5'd0);
        idle(5'd5, 64'd0, 0);
        @(negedge clk);
        check64("alu_wb_en", {63'd0, wb_en}, 64'd1);
        check64("alu_wb_rd", {59'd0, wb_rd}, 64'd5);
        check64("alu_wb_data", wb_data, 64'h1234);
        check64("alu_bypass", rs1_data, 64'h1234);
        idle(5'd5, 64'd0, 0);
        @(negedge clk);
        check64("alu_array", rs1_data, 64'h1234);
        check64("alu_retire", {32'd0, retire_count}, 64'd1);

        // Load writeback to x7
        cycle(1, 1, 1, 5'd7, 64'h5555, 64'd0, 0, 0, 5'd0, 5'd0);
        idle(5'd7, 64'hDEADBEEF_00000001, 0);
        @(negedge clk);
        check64("load_wb_data", wb_data, 64'hDEADBEEF_00000001);
        idle(5'd7, 64'd0, 0);
        @(negedge clk);
        check64("load_array", rs1_data, 64'hDEADBEEF_00000001);
        check64("load_retire", {32'd0, retire_count}, 64'd2);

        // x0 protection
        cycle(1, 1, 0, 5'd0, 64'hFF, 64'd0, 0, 0, 5'd0, 5'd0);
        idle(5'd0, 64'd0, 0);
        @(negedge clk);
        check64("x0_wb_en", {63'd0, wb_en}, 64'd0);
        check64("x0_read", rs1_data, 64'd0);
        idle(5'd0, 64'd0, 0);
        @(negedge clk);
        check64("x0_retire", {32'd0, retire_count}, 64'd3);

        // Load to x3 held across a three-cycle stall
        cycle(1, 1, 1, 5'd3, 64'h999, 64'd0, 0, 0, 5'd0, 5'd0);
        idle(5'd3, 64'hAA, 1);
        @(negedge clk);
        check64("stall_no_write", {63'd0, wb_en}, 64'd0);
        idle(5'd3, 64'hBB, 1);
        idle(5'd3, 64'hCC, 1);
        @(negedge clk);
        check64("stall_retire_held", {32'd0, retire_count}, 64'd3);
        idle(5'd3, 64'h77, 0);
        @(negedge clk);
        check64("stall_release_data", wb_data, 64'hAA);
        idle(5'd3, 64'd0, 0);
        @(negedge clk);
        check64("stall_array", rs1_data, 64'hAA);
        check64("stall_retire", {32'd0, retire_count}, 64'd4);

        // Flush takes priority over stall
        cycle(1, 1, 1, 5'd9, 64'h42, 64'h43, 1, 1, 5'd9, 5'd0);
        idle(5'd9, 64'h44, 0);
        @(negedge clk);
        check64("flush_no_write", {63'd0, wb_en}, 64'd0);
        idle(5'd9, 64'd0, 0);
        @(negedge clk);
        check64("flush_x9", rs1_data, 64'd0);
        check64("flush_retire", {32'd0, retire_count}, 64'd4);

        // Asynchronous reset while an instruction is stalled in WB
        cycle(1, 1, 0, 5'd10, 64'hABCD_0000_1111_2222, 64'd0, 0, 0, 5'd0, 5'd0);
        idle(5'd10, 64'd0, 1);
        #2;
        do_reset();
        for (int a = 0; a < 32; a += 2) begin
            idle(5'(a), 64'd0, 0);
            rs2_addr = 5'(a + 1);
            q_obs[q_obs.size() - 1].rs2 = mdl_read(rs2_addr);
            @(negedge clk);
            check64("post_reset_rs1", rs1_data, 64'd0);
            check64("post_reset_rs2", rs2_data, 64'd0);
        end

        // Randomised traffic with an extra reset halfway through
        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, rd,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1, a1, a2);
            if (i == 1500) begin
                #2;
                do_reset();
            end
        end
        idle(5'd0, 64'd0, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (q_wr.size() != 0) begin
            n_errors++;
            $display("FAIL pending_writes: got %0d outstanding expected 0", q_wr.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
